// File: rtl/alu_issue_scheduler_pkg.sv
// alu_issue_scheduler_pkg: shared widths and ALU opcodes for the ALU
// reservation station.
package alu_issue_scheduler_pkg;

  localparam int RS_ENTRY_NUM     = 4;
  localparam int RS_DATA_LEN      = 32;
  localparam int RS_ALU_OP_WIDTH  = 4;
  localparam int RS_RRF_TAG_WIDTH = 6;

  localparam logic [3:0] ALU_OP_ADD = 4'd0;
  localparam logic [3:0] ALU_OP_SUB = 4'd1;
  localparam logic [3:0] ALU_OP_AND = 4'd2;
  localparam logic [3:0] ALU_OP_OR  = 4'd3;
  localparam logic [3:0] ALU_OP_XOR = 4'd4;

endpackage

// File: rtl/alu_rs_select.sv
// alu_rs_select: lowest-index priority encoder.
// req_i -> grant_valid_o (any request), grant_idx_o (lowest set bit).
module alu_rs_select #(
  parameter int REQ_NUM = 4,
  localparam int IW = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req_i,
  output logic               grant_valid_o,
  output logic [IW-1:0]      grant_idx_o
);

  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// alu_issue_scheduler: 4-entry ALU reservation station with wakeup and
// lowest-index issue. Ports: dispatch_*, wakeup_*, registered issue_*,
// entry_count_o; clk_i, synchronous active-high reset_i, flush_i.
module alu_issue_scheduler
  import alu_issue_scheduler_pkg::*;
#(
  parameter int ENTRY_NUM     = RS_ENTRY_NUM,
  parameter int DATA_LEN      = RS_DATA_LEN,
  parameter int ALU_OP_WIDTH  = RS_ALU_OP_WIDTH,
  parameter int RRF_TAG_WIDTH = RS_RRF_TAG_WIDTH,
  localparam int IW = $clog2(ENTRY_NUM),
  localparam int CW = IW + 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     dispatch_valid_i,
  output logic                     dispatch_ready_o,
  input  logic [ALU_OP_WIDTH-1:0]  dispatch_alu_op_i,
  input  logic [DATA_LEN-1:0]      dispatch_src1_i,
  input  logic                     dispatch_src1_valid_i,
  input  logic [DATA_LEN-1:0]      dispatch_src2_i,
  input  logic                     dispatch_src2_valid_i,
  input  logic [RRF_TAG_WIDTH-1:0] dispatch_rrf_tag_i,
  input  logic                     dispatch_write_rrf_i,
  input  logic                     wakeup_valid_i,
  input  logic [RRF_TAG_WIDTH-1:0] wakeup_tag_i,
  input  logic [DATA_LEN-1:0]      wakeup_data_i,
  output logic                     issue_o,
  output logic [ALU_OP_WIDTH-1:0]  issue_alu_op_o,
  output logic [DATA_LEN-1:0]      issue_src1_o,
  output logic [DATA_LEN-1:0]      issue_src2_o,
  output logic [RRF_TAG_WIDTH-1:0] issue_rrf_tag_o,
  output logic                     issue_write_rrf_o,
  output logic [CW-1:0]            entry_count_o
);

  logic [ENTRY_NUM-1:0]     valid_q;
  logic [ENTRY_NUM-1:0]     rdy1_q;
  logic [ENTRY_NUM-1:0]     rdy2_q;
  logic [DATA_LEN-1:0]      src1_q [ENTRY_NUM];
  logic [DATA_LEN-1:0]      src2_q [ENTRY_NUM];
  logic [ALU_OP_WIDTH-1:0]  op_q   [ENTRY_NUM];
  logic [RRF_TAG_WIDTH-1:0] tag_q  [ENTRY_NUM];
  logic [ENTRY_NUM-1:0]     wr_q;

  logic [ENTRY_NUM-1:0] ready_vec;
  logic [ENTRY_NUM-1:0] wake1;
  logic [ENTRY_NUM-1:0] wake2;
  logic                 sel_vld;
  logic [IW-1:0]        sel_idx;
  logic                 free_vld;
  logic [IW-1:0]        free_idx;
  logic                 disp_fire;
  logic                 byp1;
  logic                 byp2;

  assign ready_vec = valid_q & rdy1_q & rdy2_q;

  alu_rs_select #(.REQ_NUM(ENTRY_NUM)) u_issue_sel (
    .req_i         (ready_vec),
    .grant_valid_o (sel_vld),
    .grant_idx_o   (sel_idx)
  );

  alu_rs_select #(.REQ_NUM(ENTRY_NUM)) u_free_sel (
    .req_i         (~valid_q),
    .grant_valid_o (free_vld),
    .grant_idx_o   (free_idx)
  );

  // Registered valids only: a slot freed by this cycle's issue waits a cycle.
  assign dispatch_ready_o = free_vld & ~flush_i & ~reset_i;
  assign disp_fire        = dispatch_valid_i & dispatch_ready_o;

  // Operand arriving on the broadcast bus in its own dispatch cycle.
  assign byp1 = ~dispatch_src1_valid_i & wakeup_valid_i &
                (dispatch_src1_i[RRF_TAG_WIDTH-1:0] == wakeup_tag_i);
  assign byp2 = ~dispatch_src2_valid_i & wakeup_valid_i &
                (dispatch_src2_i[RRF_TAG_WIDTH-1:0] == wakeup_tag_i);

  always_comb begin
    wake1 = '0;
    wake2 = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      wake1[i] = valid_q[i] & ~rdy1_q[i] & wakeup_valid_i &
                 (src1_q[i][RRF_TAG_WIDTH-1:0] == wakeup_tag_i);
      wake2[i] = valid_q[i] & ~rdy2_q[i] & wakeup_valid_i &
                 (src2_q[i][RRF_TAG_WIDTH-1:0] == wakeup_tag_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q           <= '0;
      issue_o           <= 1'b0;
      issue_alu_op_o    <= '0;
      issue_src1_o      <= '0;
      issue_src2_o      <= '0;
      issue_rrf_tag_o   <= '0;
      issue_write_rrf_o <= 1'b0;
      entry_count_o     <= '0;
    end else if (flush_i) begin
      valid_q       <= '0;
      issue_o       <= 1'b0;
      entry_count_o <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (wake1[i]) begin
          src1_q[i] <= wakeup_data_i;
          rdy1_q[i] <= 1'b1;
        end
        if (wake2[i]) begin
          src2_q[i] <= wakeup_data_i;
          rdy2_q[i] <= 1'b1;
        end
      end
      issue_o <= sel_vld;
      if (sel_vld) begin
        issue_alu_op_o    <= op_q[sel_idx];
        issue_src1_o      <= src1_q[sel_idx];
        issue_src2_o      <= src2_q[sel_idx];
        issue_rrf_tag_o   <= tag_q[sel_idx];
        issue_write_rrf_o <= wr_q[sel_idx];
        valid_q[sel_idx]  <= 1'b0;
      end
      if (disp_fire) begin
        valid_q[free_idx] <= 1'b1;
        op_q[free_idx]    <= dispatch_alu_op_i;
        tag_q[free_idx]   <= dispatch_rrf_tag_i;
        wr_q[free_idx]    <= dispatch_write_rrf_i;
        rdy1_q[free_idx]  <= dispatch_src1_valid_i | byp1;
        rdy2_q[free_idx]  <= dispatch_src2_valid_i | byp2;
        src1_q[free_idx]  <= byp1 ? wakeup_data_i : dispatch_src1_i;
        src2_q[free_idx]  <= byp2 ? wakeup_data_i : dispatch_src2_i;
      end
      entry_count_o <= entry_count_o + CW'(disp_fire) - CW'(sel_vld);
    end
  end

endmodule
